// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative shifter for the ALU shift path.
// Takes one request at a time and applies at most MAX_STEP bit positions
// per cycle through a narrow shift stage. Result and Z/N flags are held
// until the consumer accepts them.
module shift_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             busy
);

  // Remaining-distance width: an effective amount is always < WIDTH.
  localparam int unsigned RW = $clog2(WIDTH);
  localparam logic [RW-1:0] LP_MAX_STEP = RW'(MAX_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_work;
  logic [RW-1:0]    r_rem;
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  op_t              w_op_in;
  logic             w_sat;
  logic [RW-1:0]    w_eff;
  logic [WIDTH-1:0] w_sat_val;
  logic [RW-1:0]    w_step;
  logic [RW-1:0]    w_lsh;
  logic [RW-1:0]    w_rem_next;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_load_val;

  assign w_op_in = op_t'(op);

  // WIDTH is a power of two, so c >= WIDTH is exactly "any upper bit set",
  // and the low RW bits are both c (when c < WIDTH) and c mod WIDTH.
  assign w_sat     = (|c[WIDTH-1:RW]) && (w_op_in != OP_ROR);
  assign w_eff     = c[RW-1:0];
  assign w_sat_val = (w_op_in == OP_SRA) ? {WIDTH{a[WIDTH-1]}} : '0;

  // Per-cycle distance, clamped to the shift stage capacity.
  assign w_step     = (r_rem > LP_MAX_STEP) ? LP_MAX_STEP : r_rem;
  assign w_rem_next = r_rem - w_step;
  // Left-rotate companion amount for ROR: WIDTH - step (step is never 0 in RUN).
  assign w_lsh      = ~w_step + RW'(1);

  // One bounded shift step on the working register.
  always_comb begin
    w_shifted = r_work;
    case (r_op)
      OP_SLL:  w_shifted = r_work << w_step;
      OP_SRL:  w_shifted = r_work >> w_step;
      // The working register keeps the original sign bit in its MSB, so an
      // arithmetic shift replicates the operand's sign at every step.
      OP_SRA:  w_shifted = WIDTH'($signed(r_work) >>> w_step);
      OP_ROR:  w_shifted = (r_work >> w_step) | (r_work << w_lsh);
      default: w_shifted = r_work;
    endcase
  end

  // Value about to be captured into the result register (flags derive from it).
  always_comb begin
    w_load_val = w_shifted;
    if (r_state == S_IDLE) begin
      w_load_val = w_sat ? w_sat_val : a;
    end
  end

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_SLL;
      r_work      <= '0;
      r_rem       <= '0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= w_op_in;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_sat || (w_eff == '0)) begin
              r_result    <= w_load_val;
              r_z         <= (w_load_val == '0);
              r_n         <= w_load_val[WIDTH-1];
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_work  <= a;
              r_rem   <= w_eff;
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_result    <= w_load_val;
            r_z         <= (w_load_val == '0);
            r_n         <= w_load_val[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign z         = r_z;
  assign n         = r_n;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results and latencies,
// backpressure hold, and reset during an in-flight shift.
module tb_shift_sequencer;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        z;
  logic        n;
  logic        busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  shift_sequencer #(
    .WIDTH    (32),
    .MAX_STEP (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .n         (n),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, change inputs after acceptance, measure latency,
  // check result/flags, then hand the result off.
  task automatic do_req(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] c_i, input int lat_exp, input logic [31:0] res_exp);
    int lat;
    chk({tag, " in_ready_before"}, {31'b0, in_ready}, 32'd1);
    op       = op_i;
    a        = a_i;
    c        = c_i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op       = ~op_i;
    a        = ~a_i;
    c        = 32'd0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, " result"}, result, res_exp);
    chk({tag, " z"}, {31'b0, z}, {31'b0, (res_exp == 32'd0)});
    chk({tag, " n"}, {31'b0, n}, {31'b0, res_exp[31]});
    chk({tag, " busy_done"}, {31'b0, busy}, 32'd1);
    chk({tag, " in_ready_done"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid_after"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " in_ready_after"}, {31'b0, in_ready}, 32'd1);
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = 32'd0;
    c         = 32'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset z", {31'b0, z}, 32'd0);
    chk("reset n", {31'b0, n}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);

    do_req("srl1",     SRL, 32'h0001_1000, 32'd1,  2, 32'h0000_8800);
    do_req("sra20",    SRA, 32'h1001_0100, 32'd20, 4, 32'h0000_0100);
    do_req("sra_neg1", SRA, 32'h8000_0000, 32'd1,  2, 32'hC000_0000);
    do_req("sra_sat",  SRA, 32'h8000_0000, 32'd40, 1, 32'hFFFF_FFFF);
    do_req("sll_sat",  SLL, 32'h1234_5678, 32'd40, 1, 32'h0000_0000);
    do_req("ror33",    ROR, 32'h0000_0001, 32'd33, 2, 32'h8000_0000);
    do_req("sll0",     SLL, 32'h1234_5678, 32'd0,  1, 32'h1234_5678);
    do_req("ror64",    ROR, 32'h1234_5678, 32'd64, 1, 32'h1234_5678);
    do_req("ror12",    ROR, 32'h1234_5678, 32'd12, 3, 32'h6781_2345);
    do_req("sll31",    SLL, 32'h0000_0001, 32'd31, 5, 32'h8000_0000);
    do_req("srl31",    SRL, 32'hF000_0000, 32'd31, 5, 32'h0000_0001);
    do_req("sra32",    SRA, 32'h4000_0000, 32'd32, 1, 32'h0000_0000);
    do_req("sll8",     SLL, 32'h00AB_CDEF, 32'd8,  2, 32'hABCD_EF00);

    // Backpressure: SRA 0x80000010 by 4 -> 0xF8000001, held while in_valid pulses.
    op = SRA; a = 32'h8000_0010; c = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp out_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      op = SLL; a = 32'h0; c = 32'd0;
      tick();
      chk("bp result", result, 32'hF800_0001);
      chk("bp z", {31'b0, z}, 32'd0);
      chk("bp n", {31'b0, n}, 32'd1);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp out_valid_hold", {31'b0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp pulses ignored", {31'b0, busy}, 32'd0);

    // Reset during RUN: SLL 1 by 31, reset after two shift steps.
    op = SLL; a = 32'h0000_0001; c = 32'd31; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_mid busy", {31'b0, busy}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid result", result, 32'd0);
    chk("rst_mid in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid busy_clr", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_mid no_emit", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
